hard_png_core: RTL and testbench
================================

# hard_png_core

Hardware PNG header parser sitting behind the packet buffer. It watches the 336-bit (42-byte) buffer word and starts a parse whenever a new word begins with the PNG signature. It validates the IHDR chunk, including a byte-serial CRC-32, then publishes image parameters and the header of the following chunk to downstream logic.

## Interface
Parameters: none.
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset; synchronous, active-high despite the name
- idata  in  336  buffer word; byte 0 = idata[335:328], byte k = idata[335-8k -: 8]
- busy  out  1  parse in progress
- done  out  1  one-cycle pulse, results valid
- valid  out  1  header fully legal (err == 0); held until next done
- err  out  4  [0] length/type, [1] dimensions, [2] format fields, [3] CRC mismatch
- width  out  32  IHDR width
- height  out  32  IHDR height
- bit_depth  out  8  IHDR bit depth
- color_type  out  8  IHDR colour type
- interlace  out  1  IHDR interlace byte bit 0
- next_len  out  32  length field of the chunk after IHDR
- next_type  out  32  type field of the chunk after IHDR

## Operation
- Byte map (big-endian fields):
  - 0-7: signature 89 50 4E 47 0D 0A 1A 0A
  - 8-11: length
  - 12-15: type
  - 16-19: width
  - 20-23: height
  - 24: depth
  - 25: colour type
  - 26: compression
  - 27: filter
  - 28: interlace
  - 29-32: stored CRC
  - 33-36: next_len
  - 37-40: next_type
  - 41: ignored
- Start condition (IDLE only): bytes 0-7 equal the signature AND idata != last_word.
  - On start, capture idata into an internal frame register and into last_word, then go to CRC.
- Held input never re-triggers a parse.
- A non-signature word never starts a parse and never pulses done.
- idata changes while busy are ignored.
- CRC: CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over bytes 12-28 (17 bytes), one byte per cycle, LSB-first bitwise update.
- Checks, all evaluated in CHECK:
  - err[0]: length != 0x0000000D or type != 0x49484452.
  - err[1]: width or height == 0, or bit 31 of either set.
  - err[2]: illegal depth/colour pair, compression != 0, filter != 0, or interlace > 1. Legal pairs:
    - ct0: {1,2,4,8,16}
    - ct2: {8,16}
    - ct3: {1,2,4,8}
    - ct4: {8,16}
    - ct6: {8,16}
  - err[3]: computed CRC != stored CRC.
- Field outputs are loaded from the frame in CHECK regardless of errors.
- FSM:
  - IDLE -> CRC on start.
  - CRC (17 cycles, byte counter 0..16) -> CHECK.
  - CHECK -> IDLE, asserting done.
- Reset:
  - Forces IDLE.
  - Clears last_word, CRC register, counter and all outputs to 0.
  - A reset mid-parse aborts with no done pulse.
  - Because last_word is cleared, the same word re-parses after reset.

## Timing
- Start sampled at edge T. CRC bytes absorbed at edges T+1..T+17. CHECK registers outputs at edge T+18.
- done = 1 for exactly the cycle after edge T+18.
- valid/err/fields update in that same cycle.
- busy is high in the cycles after edges T..T+17 and low in the done cycle.
- Earliest next start is sampled at edge T+19.
- Back-to-back distinct signature words therefore complete every 19 cycles.
- Reset asserted at edge R: all outputs 0 after R. Reset has priority over a start in the same cycle.

## Test plan
- 1x1 RGB8 (bytes 16-32 = 00000001 00000001 08 02 00 00 00 907753DE), next chunk 0000000C/49444154 -> done at T+19, valid=1, err=0, width=height=1, bit_depth=8, color_type=2, next_len=0x0C, next_type=0x49444154.
- Same frame with stored CRC 907753DF -> valid=0, err=4'b1000, fields still loaded.
- Depth 16 with colour type 3 and width 0 -> err=4'b0110.
- Hold the valid frame for 100 cycles -> exactly one done. Change one byte of next_type -> second done 19 cycles after the change.
- All-zero word, then signature with byte 3 = 0x48 -> no done, busy stays 0.
- Reset asserted at cycle T+10 of a parse -> no done, outputs 0. Same word still presented after reset release -> full parse, done 19 cycles later.

Source files
------------

// File: rtl/hard_png_core_if.sv
// Bus between the packet buffer / downstream logic and hard_png_core.
//   idata      : 336-bit buffer word, byte 0 in idata[335:328]
//   busy/done  : parse in progress / one-cycle completion pulse
//   valid/err  : header legality and per-class error flags
//   width ... next_type : decoded IHDR fields and header of the following chunk
interface hard_png_core_if;
    logic [335:0] idata;
    logic         busy;
    logic         done;
    logic         valid;
    logic [3:0]   err;
    logic [31:0]  width;
    logic [31:0]  height;
    logic [7:0]   bit_depth;
    logic [7:0]   color_type;
    logic         interlace;
    logic [31:0]  next_len;
    logic [31:0]  next_type;

    // Producer of buffer words / consumer of results
    modport master (
        output idata,
        input  busy, done, valid, err, width, height, bit_depth,
               color_type, interlace, next_len, next_type
    );

    // The parser itself
    modport slave (
        input  idata,
        output busy, done, valid, err, width, height, bit_depth,
               color_type, interlace, next_len, next_type
    );
endinterface

// File: rtl/hard_png_core.sv
// PNG header parser: detects a new signature word, runs a byte-serial CRC-32
// over the IHDR type+data, validates the header and publishes its fields.
//   clk  : system clock
//   rstn : synchronous reset, active-high
//   bus  : hard_png_core_if.slave (idata in, status and fields out)
module hard_png_core (
    input  logic             clk,
    input  logic             rstn,
    hard_png_core_if.slave   bus
);
    localparam int unsigned WORD_W    = 336;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned CRC_BYTES = 17;
    localparam logic [63:0] PNG_SIG   = 64'h8950_4E47_0D0A_1A0A;
    localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0] IHDR_LEN  = 32'h0000_000D;
    localparam logic [31:0] IHDR_TYPE = 32'h4948_4452;

    typedef enum logic [1:0] {S_IDLE, S_CRC, S_CHECK} state_t;

    state_t state, state_nxt;

    // Byte 41 is never used, so the frame only keeps bytes 0..40
    logic [WORD_W-1:8]  frame,     frame_d;
    logic [WORD_W-1:0]  last_word, last_word_d;
    logic [31:0]        crc,       crc_d;
    logic [CNT_W-1:0]   cnt,       cnt_d;

    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        valid_q, valid_d;
    logic [3:0]  err_q,   err_d;
    logic [31:0] width_q, width_d, height_q, height_d;
    logic [7:0]  depth_q, depth_d, ctype_q, ctype_d;
    logic        ilace_q, ilace_d;
    logic [31:0] nlen_q,  nlen_d,  ntype_q,  ntype_d;

    logic        start;
    logic [8:0]  crc_hi;
    logic [7:0]  crc_byte;
    logic [3:0]  err_c;

    // Frame field slices (big-endian)
    wire [31:0] f_len   = frame[271:240];
    wire [31:0] f_type  = frame[239:208];
    wire [31:0] f_width = frame[207:176];
    wire [31:0] f_hgt   = frame[175:144];
    wire [7:0]  f_depth = frame[143:136];
    wire [7:0]  f_ctype = frame[135:128];
    wire [7:0]  f_comp  = frame[127:120];
    wire [7:0]  f_filt  = frame[119:112];
    wire [7:0]  f_ilace = frame[111:104];
    wire [31:0] f_crc   = frame[103:72];
    wire [31:0] f_nlen  = frame[71:40];
    wire [31:0] f_ntype = frame[39:8];

    // Reflected CRC-32 update with one byte, LSB first
    function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ({1'b0, c[31:1]} ^ CRC_POLY) : {1'b0, c[31:1]};
        end
        return c;
    endfunction

    function automatic logic depth_ok(input logic [7:0] ct, input logic [7:0] d);
        case (ct)
            8'd0:              depth_ok = (d == 8'd1) || (d == 8'd2) || (d == 8'd4) || (d == 8'd8) || (d == 8'd16);
            8'd2, 8'd4, 8'd6:  depth_ok = (d == 8'd8) || (d == 8'd16);
            8'd3:              depth_ok = (d == 8'd1) || (d == 8'd2) || (d == 8'd4) || (d == 8'd8);
            default:           depth_ok = 1'b0;
        endcase
    endfunction

    // New parse only for a signature word that differs from the last one parsed
    assign start = (state == S_IDLE) && (bus.idata[335:272] == PNG_SIG) && (bus.idata != last_word);

    // CRC covers bytes 12..28; byte 12+cnt starts at bit 239-8*cnt
    assign crc_hi   = 9'(239 - 8 * int'(cnt));
    assign crc_byte = frame[crc_hi -: 8];

    assign err_c[0] = (f_len != IHDR_LEN) || (f_type != IHDR_TYPE);
    assign err_c[1] = (f_width == 32'h0) || (f_hgt == 32'h0) || f_width[31] || f_hgt[31];
    assign err_c[2] = !depth_ok(f_ctype, f_depth) || (f_comp != 8'h0) || (f_filt != 8'h0) || (f_ilace > 8'd1);
    assign err_c[3] = (~crc) != f_crc;

    // State register
    always_ff @(posedge clk) begin
        if (rstn) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CRC;
            S_CRC:   if (cnt == CNT_W'(CRC_BYTES - 1)) state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        frame_d     = frame;
        last_word_d = last_word;
        crc_d       = crc;
        cnt_d       = cnt;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        err_d       = err_q;
        width_d     = width_q;
        height_d    = height_q;
        depth_d     = depth_q;
        ctype_d     = ctype_q;
        ilace_d     = ilace_q;
        nlen_d      = nlen_q;
        ntype_d     = ntype_q;
        case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    frame_d     = bus.idata[WORD_W-1:8];
                    last_word_d = bus.idata;
                    crc_d       = 32'hFFFF_FFFF;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                end
            end
            S_CRC: begin
                crc_d  = crc_update(crc, crc_byte);
                cnt_d  = cnt + CNT_W'(1);
                busy_d = 1'b1;
            end
            S_CHECK: begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                err_d    = err_c;
                valid_d  = (err_c == 4'h0);
                width_d  = f_width;
                height_d = f_hgt;
                depth_d  = f_depth;
                ctype_d  = f_ctype;
                ilace_d  = f_ilace[0];
                nlen_d   = f_nlen;
                ntype_d  = f_ntype;
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rstn) begin
            frame     <= '0;
            last_word <= '0;
            crc       <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= '0;
            width_q   <= '0;
            height_q  <= '0;
            depth_q   <= '0;
            ctype_q   <= '0;
            ilace_q   <= 1'b0;
            nlen_q    <= '0;
            ntype_q   <= '0;
        end else begin
            frame     <= frame_d;
            last_word <= last_word_d;
            crc       <= crc_d;
            cnt       <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            width_q   <= width_d;
            height_q  <= height_d;
            depth_q   <= depth_d;
            ctype_q   <= ctype_d;
            ilace_q   <= ilace_d;
            nlen_q    <= nlen_d;
            ntype_q   <= ntype_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.valid      = valid_q;
    assign bus.err        = err_q;
    assign bus.width      = width_q;
    assign bus.height     = height_q;
    assign bus.bit_depth  = depth_q;
    assign bus.color_type = ctype_q;
    assign bus.interlace  = ilace_q;
    assign bus.next_len   = nlen_q;
    assign bus.next_type  = ntype_q;
endmodule

// File: tb/tb_hard_png_core.sv
// Directed bench for hard_png_core: reset, valid/CRC/format errors, held
// input, non-signature words, mid-parse reset and back-to-back parses.
module tb_hard_png_core;
    logic clk;
    logic rstn;
    int   checks;
    int   passes;

    hard_png_core_if bus ();

    hard_png_core u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] IDAT = 32'h4944_4154;

    // Reference CRC-32 over 17 bytes, fed one bit at a time through the LFSR
    function automatic logic [31:0] ref_crc(input logic [135:0] d);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 17; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[128 - 8*i + b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic logic [335:0] mk(input logic [31:0] w, input logic [31:0] h,
                                        input logic [7:0] d, input logic [7:0] ct,
                                        input logic [7:0] cm, input logic [7:0] fl,
                                        input logic [7:0] il, input logic [31:0] crc,
                                        input logic [31:0] nl, input logic [31:0] nt);
        return {64'h8950_4E47_0D0A_1A0A, 32'h0000_000D, 32'h4948_4452,
                w, h, d, ct, cm, fl, il, crc, nl, nt, 8'h00};
    endfunction

    function automatic logic [335:0] mk_ok(input logic [31:0] w, input logic [31:0] h,
                                           input logic [7:0] d, input logic [7:0] ct,
                                           input logic [7:0] il,
                                           input logic [31:0] nl, input logic [31:0] nt);
        return mk(w, h, d, ct, 8'h0, 8'h0, il,
                  ref_crc({32'h4948_4452, w, h, d, ct, 8'h0, 8'h0, il}), nl, nt);
    endfunction

    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b1;
        bus.idata = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0)  $display("FAIL reset_busy got %0b want 0", bus.busy);  else passes++;
        checks++; if (bus.done !== 1'b0)  $display("FAIL reset_done got %0b want 0", bus.done);  else passes++;
        checks++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.valid); else passes++;
        checks++; if (bus.err !== 4'h0)   $display("FAIL reset_err got %h want 0", bus.err);     else passes++;
        checks++; if (bus.width !== 32'h0) $display("FAIL reset_width got %h want 0", bus.width); else passes++;
        rstn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_valid_frame;
        int  lat;
        logic busy_ok;
        lat = -1;
        busy_ok = 1'b1;
        bus.idata = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DE, 32'h0000_000C, IDAT);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = k; break; end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++; if (lat !== 19) $display("FAIL valid_latency got %0d want 19", lat); else passes++;
        checks++; if (busy_ok !== 1'b1) $display("FAIL valid_busy_during got 0 want 1"); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL valid_busy_done got %0b want 0", bus.busy); else passes++;
        checks++; if (bus.valid !== 1'b1) $display("FAIL valid_valid got %0b want 1", bus.valid); else passes++;
        checks++; if (bus.err !== 4'h0) $display("FAIL valid_err got %h want 0", bus.err); else passes++;
        checks++; if (bus.width !== 32'd1 || bus.height !== 32'd1)
            $display("FAIL valid_dims got %0d x %0d want 1 x 1", bus.width, bus.height); else passes++;
        checks++; if (bus.bit_depth !== 8'd8 || bus.color_type !== 8'd2 || bus.interlace !== 1'b0)
            $display("FAIL valid_fmt got d%0d ct%0d i%0b want d8 ct2 i0", bus.bit_depth, bus.color_type, bus.interlace); else passes++;
        checks++; if (bus.next_len !== 32'h0C || bus.next_type !== IDAT)
            $display("FAIL valid_next got %h/%h want 0000000c/%h", bus.next_len, bus.next_type, IDAT); else passes++;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) $display("FAIL valid_done_pulse got %0b want 0", bus.done); else passes++;
        checks++; if (bus.valid !== 1'b1) $display("FAIL valid_held got %0b want 1", bus.valid); else passes++;
    endtask

    task automatic test_crc_error;
        int lat;
        bus.idata = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DF, 32'h0000_000C, IDAT);
        wait_done(40, lat);
        checks++; if (lat !== 19) $display("FAIL crc_latency got %0d want 19", lat); else passes++;
        checks++; if (bus.valid !== 1'b0 || bus.err !== 4'b1000)
            $display("FAIL crc_err got v%0b e%b want v0 e1000", bus.valid, bus.err); else passes++;
        checks++; if (bus.width !== 32'd1 || bus.color_type !== 8'd2)
            $display("FAIL crc_fields got w%0d ct%0d want w1 ct2", bus.width, bus.color_type); else passes++;
    endtask

    task automatic test_format_error;
        int lat;
        bus.idata = mk_ok(32'd0, 32'd1, 8'd16, 8'd3, 8'd0, 32'h0000_000C, IDAT);
        wait_done(40, lat);
        checks++; if (lat !== 19) $display("FAIL fmt_latency got %0d want 19", lat); else passes++;
        checks++; if (bus.err !== 4'b0110 || bus.valid !== 1'b0)
            $display("FAIL fmt_err got v%0b e%b want v0 e0110", bus.valid, bus.err); else passes++;
        checks++; if (bus.bit_depth !== 8'd16 || bus.width !== 32'd0)
            $display("FAIL fmt_fields got d%0d w%0d want d16 w0", bus.bit_depth, bus.width); else passes++;
        @(negedge clk);
        // Interlace 1 is legal, interlace 2 is a format error
        bus.idata = mk_ok(32'd640, 32'd480, 8'd8, 8'd6, 8'd1, 32'h0000_000C, IDAT);
        wait_done(40, lat);
        checks++; if (bus.valid !== 1'b1 || bus.interlace !== 1'b1 || bus.width !== 32'd640)
            $display("FAIL ilace1 got v%0b i%0b w%0d want v1 i1 w640", bus.valid, bus.interlace, bus.width); else passes++;
        @(negedge clk);
        bus.idata = mk_ok(32'd640, 32'd480, 8'd8, 8'd6, 8'd2, 32'h0000_000C, IDAT);
        wait_done(40, lat);
        checks++; if (bus.err !== 4'b0100 || bus.interlace !== 1'b0)
            $display("FAIL ilace2 got e%b i%0b want e0100 i0", bus.err, bus.interlace); else passes++;
        @(negedge clk);
    endtask

    task automatic test_hold;
        int dones;
        int lat;
        logic [335:0] w;
        dones = 0;
        w = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DE, 32'h0000_000C, IDAT);
        bus.idata = w;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones !== 1) $display("FAIL hold_dones got %0d want 1", dones); else passes++;
        w[39:32] = 8'h4A;
        bus.idata = w;
        wait_done(40, lat);
        checks++; if (lat !== 19) $display("FAIL hold_change_latency got %0d want 19", lat); else passes++;
        checks++; if (bus.next_type !== 32'h4A44_4154 || bus.valid !== 1'b1)
            $display("FAIL hold_change_next got %h v%0b want 4a444154 v1", bus.next_type, bus.valid); else passes++;
        @(negedge clk);
    endtask

    task automatic test_no_signature;
        int dones;
        logic busy_seen;
        logic [335:0] w;
        dones = 0;
        busy_seen = 1'b0;
        bus.idata = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        w = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DE, 32'h0000_000C, IDAT);
        w[311:304] = 8'h48;
        bus.idata = w;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (dones !== 0) $display("FAIL nosig_dones got %0d want 0", dones); else passes++;
        checks++; if (busy_seen !== 1'b0) $display("FAIL nosig_busy got 1 want 0"); else passes++;
    endtask

    task automatic test_reset_abort;
        int dones;
        int lat;
        dones = 0;
        bus.idata = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DE, 32'h0000_000C, IDAT);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_before got %0b want 1", bus.busy); else passes++;
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.err !== 4'h0 ||
                      bus.width !== 32'h0 || bus.next_type !== 32'h0)
            $display("FAIL abort_outputs got b%0b v%0b e%h w%h nt%h want all 0",
                     bus.busy, bus.valid, bus.err, bus.width, bus.next_type); else passes++;
        rstn = 1'b0;
        wait_done(40, lat);
        checks++; if (dones !== 0) $display("FAIL abort_dones got %0d want 0", dones); else passes++;
        checks++; if (lat !== 19) $display("FAIL abort_reparse_latency got %0d want 19", lat); else passes++;
        checks++; if (bus.valid !== 1'b1 || bus.next_len !== 32'h0C)
            $display("FAIL abort_reparse got v%0b nl%h want v1 nl0000000c", bus.valid, bus.next_len); else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        int lat2;
        logic [31:0] nl_a;
        lat = -1;
        bus.idata = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DE, 32'h0000_0010, IDAT);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            // Change the input mid-parse: ignored now, parsed right after done
            if (k == 5)
                bus.idata = mk(32'd1, 32'd1, 8'd8, 8'd2, 8'd0, 8'd0, 8'd0, 32'h9077_53DE, 32'h0000_0020, IDAT);
            if (bus.done === 1'b1) begin lat = k; break; end
        end
        nl_a = bus.next_len;
        wait_done(40, lat2);
        checks++; if (lat !== 19) $display("FAIL b2b_first_latency got %0d want 19", lat); else passes++;
        checks++; if (nl_a !== 32'h10) $display("FAIL b2b_first_next_len got %h want 00000010", nl_a); else passes++;
        checks++; if (lat2 !== 19) $display("FAIL b2b_second_latency got %0d want 19", lat2); else passes++;
        checks++; if (bus.next_len !== 32'h20 || bus.valid !== 1'b1)
            $display("FAIL b2b_second got nl%h v%0b want nl00000020 v1", bus.next_len, bus.valid); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rstn = 1'b1;
        bus.idata = '0;
        test_reset();
        test_valid_frame();
        test_crc_error();
        test_format_error();
        test_hold();
        test_no_signature();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
